counter_sequencer: RTL and testbench

Controller that time-shares one 3-bit sequence counter between NREQ requesters. Each request asks for a run of N consecutive counter values in in-order or out-of-order mode. The block round-robin arbitrates, holds the counter in reset while idle, steers its `inorder` and `reset` inputs during a run, and streams the sampled values back tagged with the owner. It sits between the requesting logic and the counter instance, which it drives through the `ctr_*` ports.

---
 rtl/counter_sequencer_pkg.sv | 14 +
 rtl/counter_sequencer_rr_arbiter.sv | 44 ++++
 rtl/counter_sequencer.sv | 133 +++++++++++++
 tb/tb_counter_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer.
package counter_sequencer_pkg;

  // Width of the shared sequence counter value.
  localparam int CTR_W = 3;

  // Controller states; encodings match the original header.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot winner from the current priority pointer.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt_next
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_after;

  // Scan from the pointer upward; the first active request wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_next  = '0;
    ptr_after = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt_next[idx] = 1'b1;
        ptr_after     = PW'((idx + 1) % NREQ);
        found         = 1'b1;
      end
    end
  end

  // Priority moves to the requester after the winner once a grant is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_after;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Time-shares one sequence counter between NREQ requesters, streaming
// the sampled values back tagged with the owning requester.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int  NREQ  = 2,
  parameter int  LEN_W = 4,
  localparam int OWN_W = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       req_mode,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  out_valid,
  output logic [CTR_W-1:0]      out_data,
  output logic [OWN_W-1:0]      out_owner,
  output logic                  ctr_reset,
  output logic                  ctr_inorder,
  input  logic [CTR_W-1:0]      ctr_count
);

  state_t             state, state_d;
  logic [OWN_W-1:0]   owner, owner_d;
  logic [LEN_W:0]     rem, rem_d;
  logic [NREQ-1:0]    gnt_d, done_d, win;
  logic               busy_d, out_valid_d, ctr_reset_d, ctr_inorder_d;
  logic [CTR_W-1:0]   out_data_d;
  logic [OWN_W-1:0]   out_owner_d, win_idx;
  logic [LEN_W-1:0]   win_len;
  logic               advance;

  // busy still high in IDLE marks the cycle right after done; no grant
  // there, which provides the mandatory idle gap between runs.
  assign advance = (state == IDLE) && !busy && (|req);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .advance  (advance),
    .gnt_next (win)
  );

  // Encode the one-hot winner and fetch its requested length.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = OWN_W'(i);
    end
    win_len = req_len[win_idx*LEN_W +: LEN_W];
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state;
    owner_d       = owner;
    rem_d         = rem;
    gnt_d         = '0;
    done_d        = '0;
    busy_d        = busy;
    out_valid_d   = 1'b0;
    out_data_d    = out_data;
    out_owner_d   = out_owner;
    ctr_reset_d   = ctr_reset;
    ctr_inorder_d = ctr_inorder;
    case (state)
      IDLE: begin
        ctr_reset_d = 1'b1;
        if (busy) begin
          busy_d = 1'b0;
        end else if (advance) begin
          gnt_d         = win;
          busy_d        = 1'b1;
          owner_d       = win_idx;
          rem_d         = (win_len == '0) ? (LEN_W+1)'(1 << LEN_W) : {1'b0, win_len};
          ctr_inorder_d = req_mode[win_idx];
          ctr_reset_d   = 1'b0;
          state_d       = RUN;
        end
      end
      RUN: begin
        out_valid_d = 1'b1;
        out_data_d  = ctr_count;
        out_owner_d = owner;
        rem_d       = rem - 1'b1;
        if (rem == (LEN_W+1)'(1)) begin
          ctr_reset_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        done_d[owner] = 1'b1;
        ctr_inorder_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any run in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= '0;
      rem         <= '0;
      gnt         <= '0;
      done        <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_owner   <= '0;
      ctr_reset   <= 1'b1;
      ctr_inorder <= 1'b0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      rem         <= rem_d;
      gnt         <= gnt_d;
      done        <= done_d;
      busy        <= busy_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_owner   <= out_owner_d;
      ctr_reset   <= ctr_reset_d;
      ctr_inorder <= ctr_inorder_d;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural sequence counter.
module tb_counter_sequencer;

  logic       clock;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] req_len;
  logic [1:0] req_mode;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       out_valid;
  logic [2:0] out_data;
  logic [0:0] out_owner;
  logic       ctr_reset;
  logic       ctr_inorder;
  logic [2:0] ctr_count;

  int vectors = 0;
  int miscompares = 0;
  int cidx = 0;
  logic [2:0] exp_q[$];

  counter_sequencer #(.NREQ(2), .LEN_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_len     (req_len),
    .req_mode    (req_mode),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_owner   (out_owner),
    .ctr_reset   (ctr_reset),
    .ctr_inorder (ctr_inorder),
    .ctr_count   (ctr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sequence counter: state 0 only after reset, then a repeating cycle.
  always @(posedge clock) begin
    if (ctr_reset) cidx <= 0;
    else           cidx <= cidx + 1;
  end

  always_comb begin
    logic [2:0] tab7 [7];
    logic [2:0] tab6 [6];
    tab7 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
    tab6 = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6};
    if (cidx == 0)        ctr_count = 3'd0;
    else if (ctr_inorder) ctr_count = tab7[(cidx - 1) % 7];
    else                  ctr_count = tab6[(cidx - 1) % 6];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One solo run from requester 'who'; expected samples come from exp_q.
  task automatic do_run(input int who, input logic mode, input logic [3:0] len);
    int n;
    n = exp_q.size();
    req = '0;
    req[who] = 1'b1;
    req_mode[who] = mode;
    req_len[who*4 +: 4] = len;
    tick;
    chk("gnt", 32'(gnt), 32'(1 << who));
    chk("busy_on", 32'(busy), 32'd1);
    chk("ctr_reset_run", 32'(ctr_reset), 32'd0);
    chk("ctr_inorder", 32'(ctr_inorder), 32'(mode));
    req = '0;
    for (int k = 0; k < n; k++) begin
      tick;
      chk("valid", 32'(out_valid), 32'd1);
      chk("data", 32'(out_data), 32'(exp_q[k]));
      chk("owner", 32'(out_owner), 32'(who));
    end
    tick;
    chk("valid_off", 32'(out_valid), 32'd0);
    chk("done", 32'(done), 32'(1 << who));
    chk("ctr_reset_done", 32'(ctr_reset), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    tick;
    chk("done_off", 32'(done), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("gnt_idle", 32'(gnt), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    req_len  = '0;
    req_mode = '0;
    tick;
    tick;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_owner", 32'(out_owner), 32'd0);
    chk("rst_ctr_reset", 32'(ctr_reset), 32'd1);
    chk("rst_inorder", 32'(ctr_inorder), 32'd0);
    reset_n = 1'b1;
    tick;

    // Requester 0, in-order, length 4.
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    do_run(0, 1'b1, 4'd4);

    // Requester 1, out-of-order, length 7.
    exp_q = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6};
    do_run(1, 1'b0, 4'd7);

    // Both held high, length 2 each: grants alternate 0,1,0,1.
    req_len  = {4'd2, 4'd2};
    req_mode = 2'b11;
    req      = 2'b11;
    for (int r = 0; r < 4; r++) begin
      tick;
      chk("alt_gnt", 32'(gnt), (r % 2 == 0) ? 32'd1 : 32'd2);
      for (int k = 0; k < 2; k++) begin
        tick;
        chk("alt_valid", 32'(out_valid), 32'd1);
        chk("alt_data", 32'(out_data), 32'(k));
        chk("alt_owner", 32'(out_owner), 32'(r % 2));
      end
      tick;
      chk("alt_valid_off", 32'(out_valid), 32'd0);
      chk("alt_done", 32'(done), (r % 2 == 0) ? 32'd1 : 32'd2);
      if (r == 3) req = '0;
      tick;
      chk("alt_idle_gnt", 32'(gnt), 32'd0);
      chk("alt_idle_busy", 32'(busy), 32'd0);
    end

    // Requester 0, in-order, length 9: state 7 holds 6.
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd1};
    do_run(0, 1'b1, 4'd9);

    // Length 0 means 16 samples.
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6,
              3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd1};
    do_run(0, 1'b1, 4'd0);

    // Reset during the 3rd valid of a length-6 run.
    req = 2'b01;
    req_mode = 2'b01;
    req_len = {4'd1, 4'd6};
    tick;
    chk("mr_gnt", 32'(gnt), 32'd1);
    req = '0;
    tick;
    tick;
    tick;
    chk("mr_valid3", 32'(out_valid), 32'd1);
    chk("mr_data3", 32'(out_data), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ctr_reset", 32'(ctr_reset), 32'd1);
    chk("mr_done", 32'(done), 32'd0);
    tick;
    reset_n = 1'b1;
    req_len = {4'd1, 4'd1};
    req_mode = 2'b11;
    req = 2'b11;
    tick;
    chk("post_gnt0", 32'(gnt), 32'd1);
    chk("post_done_none", 32'(done), 32'd0);
    tick;
    chk("post_data0", 32'(out_data), 32'd0);
    chk("post_owner0", 32'(out_owner), 32'd0);
    tick;
    chk("post_done0", 32'(done), 32'd1);
    req = 2'b10;
    tick;
    tick;
    chk("post_gnt1", 32'(gnt), 32'd2);
    req = '0;
    tick;
    chk("post_owner1", 32'(out_owner), 32'd1);
    tick;
    chk("post_done1", 32'(done), 32'd2);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
